// File: rtl/pe_stream_array_if.sv
// Operand / drain bus of the PE stream array.
// master = operand fetch + psum writeback side, slave = the array.
interface pe_stream_array_if #(
  parameter int ROW          = 4,
  parameter int COL          = 4,
  parameter int IN_BITWIDTH  = 16,
  parameter int OUT_BITWIDTH = 16,
  parameter int LANES        = 32,
  parameter int SEL_W        = 5,
  parameter int PSUM_ADDR_W  = 2
);
  localparam int ROW_W = (ROW > 1) ? $clog2(ROW) : 1;

  logic                             mac_valid;
  logic                             mac_ready;
  logic [ROW*COL-1:0]               mac_en;
  logic [LANES*IN_BITWIDTH-1:0]     actv_data;
  logic [LANES*IN_BITWIDTH-1:0]     wgt_data;
  logic [SEL_W*ROW*COL-1:0]         actv_sel;
  logic [SEL_W*ROW*COL-1:0]         wgt_sel;
  logic [PSUM_ADDR_W-1:0]           psum_addr;
  logic                             acc_first;
  logic                             drain_start;
  logic [PSUM_ADDR_W-1:0]           drain_addr;
  logic                             drain_clear;
  logic                             busy;
  logic                             out_valid;
  logic                             out_ready;
  logic [ROW_W-1:0]                 out_row;
  logic [OUT_BITWIDTH*COL-1:0]      out_data;
  logic                             out_last;

  modport master (
    output mac_valid, mac_en, actv_data, wgt_data, actv_sel, wgt_sel,
           psum_addr, acc_first, drain_start, drain_addr, drain_clear, out_ready,
    input  mac_ready, busy, out_valid, out_row, out_data, out_last
  );

  modport slave (
    input  mac_valid, mac_en, actv_data, wgt_data, actv_sel, wgt_sel,
           psum_addr, acc_first, drain_start, drain_addr, drain_clear, out_ready,
    output mac_ready, busy, out_valid, out_row, out_data, out_last
  );
endinterface

// File: rtl/pe_stream_array.sv
// ROW x COL signed MAC array with per-PE psum banks and a row-serial,
// saturating drain engine.

// One PE: lane mux, product register, accumulator bank.
module pe_stream_pe #(
  parameter int IN_BITWIDTH  = 16,
  parameter int ACC_BITWIDTH = 40,
  parameter int LANES        = 32,
  parameter int SEL_W        = 5,
  parameter int PSUM_DEPTH   = 4,
  parameter int PSUM_ADDR_W  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fire_i,
  input  logic                          en_i,
  input  logic [LANES*IN_BITWIDTH-1:0]  actv_i,
  input  logic [LANES*IN_BITWIDTH-1:0]  wgt_i,
  input  logic [SEL_W-1:0]              actv_sel_i,
  input  logic [SEL_W-1:0]              wgt_sel_i,
  input  logic [PSUM_ADDR_W-1:0]        addr_i,
  input  logic                          first_i,
  input  logic                          clr_i,
  input  logic [PSUM_ADDR_W-1:0]        rd_addr_i,
  output logic [ACC_BITWIDTH-1:0]       rd_o
);
  localparam int PW = 2*IN_BITWIDTH;

  logic signed [IN_BITWIDTH-1:0]  a_op, w_op;
  logic signed [PW-1:0]           prod_q;
  logic signed [ACC_BITWIDTH-1:0] prod_ext;
  logic                           en_q, first_q;
  logic [PSUM_ADDR_W-1:0]         addr_q;
  logic [PSUM_DEPTH-1:0][ACC_BITWIDTH-1:0] acc_q;

  // lane mux; selects past the last lane fall back to lane 0
  always_comb begin
    int unsigned ai, wi;
    ai = 32'(actv_sel_i);
    wi = 32'(wgt_sel_i);
    if (ai >= LANES) ai = 0;
    if (wi >= LANES) wi = 0;
    a_op = actv_i[IN_BITWIDTH*ai +: IN_BITWIDTH];
    w_op = wgt_i[IN_BITWIDTH*wi +: IN_BITWIDTH];
  end

  // stage 1: product plus beat control, only for enabled PEs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      first_q <= 1'b0;
      addr_q  <= '0;
      prod_q  <= '0;
    end else begin
      en_q <= fire_i & en_i;
      if (fire_i & en_i) begin
        prod_q  <= PW'(a_op) * PW'(w_op);
        addr_q  <= addr_i;
        first_q <= first_i;
      end
    end
  end

  assign prod_ext = ACC_BITWIDTH'(prod_q);

  // stage 2: read-modify-write of one entry per cycle; drain clear never
  // overlaps a MAC write since drains only start with the pipe empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_q) begin
      acc_q[addr_q] <= first_q ? prod_ext : acc_q[addr_q] + prod_ext;
    end else if (clr_i) begin
      acc_q[rd_addr_i] <= '0;
    end
  end

  assign rd_o = acc_q[rd_addr_i];
endmodule

module pe_stream_array #(
  parameter int ROW          = 4,
  parameter int COL          = 4,
  parameter int IN_BITWIDTH  = 16,
  parameter int ACC_BITWIDTH = 40,
  parameter int OUT_BITWIDTH = 16,
  parameter int LANES        = 32,
  parameter int SEL_W        = 5,
  parameter int PSUM_DEPTH   = 4,
  parameter int PSUM_ADDR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  pe_stream_array_if.slave  bus
);
  localparam int ROW_W  = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int STAGES = 2;
  localparam logic signed [ACC_BITWIDTH-1:0] SAT_HI =
    {{(ACC_BITWIDTH-OUT_BITWIDTH+1){1'b0}}, {(OUT_BITWIDTH-1){1'b1}}};
  localparam logic signed [ACC_BITWIDTH-1:0] SAT_LO =
    {{(ACC_BITWIDTH-OUT_BITWIDTH+1){1'b1}}, {(OUT_BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [STAGES:1]         vld_pipe_q;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [PSUM_ADDR_W-1:0]  daddr_q;
  logic                    dclr_q;
  logic                    take, fire, out_vld, hs, last;
  logic [ROW-1:0][COL-1:0][ACC_BITWIDTH-1:0] rd;

  function automatic logic [OUT_BITWIDTH-1:0] sat(input logic signed [ACC_BITWIDTH-1:0] v);
    if (v > SAT_HI)      return SAT_HI[OUT_BITWIDTH-1:0];
    else if (v < SAT_LO) return SAT_LO[OUT_BITWIDTH-1:0];
    else                 return v[OUT_BITWIDTH-1:0];
  endfunction

  assign out_vld = (state_q == DRAIN);
  assign last    = out_vld && (row_q == ROW_W'(ROW-1));
  assign hs      = out_vld && bus.out_ready;
  assign fire    = bus.mac_valid && bus.mac_ready;

  // drain FSM next state; a drain is only taken with the MAC pipe empty
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    take    = 1'b0;
    case (state_q)
      IDLE: if (bus.drain_start && vld_pipe_q == '0) begin
        take    = 1'b1;
        state_d = DRAIN;
        row_d   = '0;
      end
      DRAIN: if (hs) begin
        row_d = last ? '0 : row_q + ROW_W'(1);
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, row counter, drain request latch and pipeline valid shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      daddr_q    <= '0;
      dclr_q     <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], fire};
      if (take) begin
        daddr_q <= bus.drain_addr;
        dclr_q  <= bus.drain_clear;
      end
    end
  end

  // out_data depends only on registered state, never on out_ready
  always_comb begin
    bus.out_data = '0;
    if (out_vld)
      for (int j = 0; j < COL; j++)
        bus.out_data[OUT_BITWIDTH*j +: OUT_BITWIDTH] = sat(rd[row_q][j]);
  end

  assign bus.mac_ready = (state_q == IDLE) && !take;
  assign bus.busy      = (|vld_pipe_q) || (state_q != IDLE);
  assign bus.out_valid = out_vld;
  assign bus.out_row   = row_q;
  assign bus.out_last  = last;

  for (genvar i = 0; i < ROW; i++) begin : g_row
    for (genvar j = 0; j < COL; j++) begin : g_col
      localparam int P = COL*i + j;
      pe_stream_pe #(
        .IN_BITWIDTH (IN_BITWIDTH),
        .ACC_BITWIDTH(ACC_BITWIDTH),
        .LANES       (LANES),
        .SEL_W       (SEL_W),
        .PSUM_DEPTH  (PSUM_DEPTH),
        .PSUM_ADDR_W (PSUM_ADDR_W)
      ) u_pe (
        .clk       (clk),
        .rst       (reset),
        .fire_i    (fire),
        .en_i      (bus.mac_en[P]),
        .actv_i    (bus.actv_data),
        .wgt_i     (bus.wgt_data),
        .actv_sel_i(bus.actv_sel[SEL_W*P +: SEL_W]),
        .wgt_sel_i (bus.wgt_sel[SEL_W*P +: SEL_W]),
        .addr_i    (bus.psum_addr),
        .first_i   (bus.acc_first),
        .clr_i     (hs && dclr_q && (row_q == ROW_W'(i))),
        .rd_addr_i (daddr_q),
        .rd_o      (rd[i][j])
      );
    end
  end
endmodule
